dense_window_mac: RTL



---
 rtl/dense_window_mac.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dense_window_mac.sv
// Purpose : snapshot an N-element unsigned-pixel / signed-weight window on start
//           and accumulate one signed product per clock into a dot product.
// Latency : start sampled at capture edge t0 -> result_valid high after edge t0+N.
// Backpressure: none; start is ignored while busy, and the result is held until
//           the next completion.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start                   request, sampled only while idle
//   window_in  [8*N-1:0]    unsigned pixel bytes, element i = bits [8i+7:8i]
//   weights_in [8*N-1:0]    signed weight bytes,  element i = bits [8i+7:8i]
//   busy                    high while a computation is in progress
//   result_valid            one-cycle pulse when result updates
//   result [ACC_WIDTH-1:0]  signed dot product (wraps modulo 2^ACC_WIDTH)
//
// Optional feature: define DENSE_WINDOW_MAC_RELU_EN to clamp negative final sums
// to zero before they are registered into result (latency unchanged).
// ACC_WIDTH must be at least 17 so a single product fits in the accumulator.

module dense_window_mac #(
  parameter int P_SR_DEPTH  = 3,
  parameter int NUM_SR_ROWS = 3,
  parameter int ACC_WIDTH   = 20
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [8*P_SR_DEPTH*NUM_SR_ROWS-1:0]   window_in,
  input  logic [8*P_SR_DEPTH*NUM_SR_ROWS-1:0]   weights_in,
  output logic                                  busy,
  output logic                                  result_valid,
  output logic signed [ACC_WIDTH-1:0]           result
);

  localparam int N      = P_SR_DEPTH * NUM_SR_ROWS;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PROD_W = 17;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  pix_q [N];
  logic [7:0]                  pix_d [N];
  logic [7:0]                  wgt_q [N];
  logic [7:0]                  wgt_d [N];
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        busy_q, busy_d;
  logic                        result_valid_q, result_valid_d;
  logic signed [ACC_WIDTH-1:0] result_q, result_d;

  logic [7:0]                  pix_cur;
  logic [7:0]                  wgt_cur;
  logic signed [PROD_W-1:0]    pix_ext;
  logic signed [PROD_W-1:0]    wgt_ext;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] final_val;

  // Datapath: select the current element of the snapshot and form the product.
  always_comb begin
    pix_cur = 8'd0;
    wgt_cur = 8'd0;
    // Explicit mux keeps the select in range when N is not a power of two.
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        pix_cur = pix_q[i];
        wgt_cur = wgt_q[i];
      end
    end
    // Pixel is unsigned: zero-extend. Weight is signed: sign-extend.
    // The 9b x 8b product always fits in 17 signed bits, so no overflow here.
    pix_ext  = {{(PROD_W-8){1'b0}}, pix_cur};
    wgt_ext  = {{(PROD_W-8){wgt_cur[7]}}, wgt_cur};
    prod     = pix_ext * wgt_ext;
    prod_ext = ACC_WIDTH'(prod);
    sum      = acc_q + prod_ext;
`ifdef DENSE_WINDOW_MAC_RELU_EN
    final_val = sum[ACC_WIDTH-1] ? '0 : sum;
`else
    final_val = sum;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    busy_d         = busy_q;
    result_d       = result_q;
    result_valid_d = 1'b0;  // pulse drops at the next edge unconditionally
    for (int i = 0; i < N; i++) begin
      pix_d[i] = pix_q[i];
      wgt_d[i] = wgt_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Snapshot lets the upstream window keep shifting during the MAC.
          for (int i = 0; i < N; i++) begin
            pix_d[i] = window_in[8*i +: 8];
            wgt_d[i] = weights_in[8*i +: 8];
          end
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          result_d       = final_val;
          result_valid_d = 1'b1;
          busy_d         = 1'b0;
          idx_d          = '0;
          state_d        = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      idx_q          <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      for (int i = 0; i < N; i++) begin
        pix_q[i] <= 8'd0;
        wgt_q[i] <= 8'd0;
      end
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      for (int i = 0; i < N; i++) begin
        pix_q[i] <= pix_d[i];
        wgt_q[i] <= wgt_d[i];
      end
    end
  end

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;

endmodule
